// File: rtl/img_binarize_loader_if.sv
// Pixel-stream and binarized-frame signals of img_binarize_loader.
// The master side drives pixels and acks; the slave side (the loader) returns the frame.
interface img_binarize_loader_if #(
    parameter int N = 100
);
    logic [7:0]   pix_in;
    logic         pix_valid;
    logic         pix_sof;
    logic         pix_ready;
    logic [N-1:0] img;
    logic         img_valid;
    logic         img_ack;
    logic         sof_err;
    logic [7:0]   frame_cnt;

    modport master (
        output pix_in, pix_valid, pix_sof, img_ack,
        input  pix_ready, img, img_valid, sof_err, frame_cnt
    );

    modport slave (
        input  pix_in, pix_valid, pix_sof, img_ack,
        output pix_ready, img, img_valid, sof_err, frame_cnt
    );
endinterface

// File: rtl/img_binarize_loader.sv
// Thresholds a raster grayscale stream into a W*H bit frame and holds it until acked.
// Raster pixel k ends up at img[N-1-k] because the fill register shifts in from the LSB.
module img_binarize_loader #(
    parameter int         W      = 10,
    parameter int         H      = 10,
    parameter logic [7:0] THRESH = 8'd128
) (
    input  logic                 clk,
    input  logic                 rst_n,
    img_binarize_loader_if.slave bus
);
    localparam int N  = W * H;
    localparam int CW = $clog2(N + 1);
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        HOLD
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] count_q, count_d;
    logic [N-1:0]  fill_q, fill_d;
    logic [N-1:0]  img_q, img_d;
    logic          img_valid_q, img_valid_d;
    logic          sof_err_q, sof_err_d;
    logic          pix_ready_q, pix_ready_d;
    logic [7:0]    frame_cnt_q, frame_cnt_d;

    logic          accept;
    logic          pix_bit;
    logic [N-1:0]  fill_shift;

    assign accept     = bus.pix_valid & pix_ready_q;
    assign pix_bit    = (bus.pix_in >= THRESH);
    assign fill_shift = (fill_q << 1) | N'(pix_bit);

    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        fill_d      = fill_q;
        img_d       = img_q;
        img_valid_d = img_valid_q;
        sof_err_d   = 1'b0;
        frame_cnt_d = frame_cnt_q;

        unique case (state_q)
            IDLE: begin
                if (accept && bus.pix_sof) begin
                    // A one-pixel frame is complete as soon as its only pixel arrives
                    if (LAST == '0) begin
                        img_d       = N'(pix_bit);
                        img_valid_d = 1'b1;
                        frame_cnt_d = frame_cnt_q + 8'd1;
                        count_d     = '0;
                        state_d     = HOLD;
                    end else begin
                        fill_d  = N'(pix_bit);
                        count_d = CW'(1);
                        state_d = FILL;
                    end
                end
            end
            FILL: begin
                if (accept) begin
                    if (bus.pix_sof) begin
                        fill_d    = N'(pix_bit);
                        count_d   = CW'(1);
                        sof_err_d = 1'b1;
                    end else if (count_q == LAST) begin
                        img_d       = fill_shift;
                        img_valid_d = 1'b1;
                        frame_cnt_d = frame_cnt_q + 8'd1;
                        count_d     = '0;
                        state_d     = HOLD;
                    end else begin
                        fill_d  = fill_shift;
                        count_d = count_q + CW'(1);
                    end
                end
            end
            HOLD: begin
                if (bus.img_ack) begin
                    img_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Ready is registered from the next state so it never depends combinationally on inputs
        pix_ready_d = (state_d != HOLD);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            count_q     <= '0;
            fill_q      <= '0;
            img_q       <= '0;
            img_valid_q <= 1'b0;
            sof_err_q   <= 1'b0;
            pix_ready_q <= 1'b1;
            frame_cnt_q <= 8'd0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            fill_q      <= fill_d;
            img_q       <= img_d;
            img_valid_q <= img_valid_d;
            sof_err_q   <= sof_err_d;
            pix_ready_q <= pix_ready_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    assign bus.pix_ready = pix_ready_q;
    assign bus.img       = img_q;
    assign bus.img_valid = img_valid_q;
    assign bus.sof_err   = sof_err_q;
    assign bus.frame_cnt = frame_cnt_q;
endmodule

// File: tb/tb_img_binarize_loader.sv
// Self-checking bench for img_binarize_loader (10x10, threshold 128).
// Expected frames come from thresholding the pixel list the bench itself sends.
module tb_img_binarize_loader;
    localparam int N = 100;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    img_binarize_loader_if #(.N(N)) bus ();

    img_binarize_loader #(
        .W(10),
        .H(10),
        .THRESH(8'd128)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus.slave)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passed = 0;
    int exp_frames = 0;
    int sof_err_seen = 0;
    int frame_px[N];

    // Reference: raster pixel k thresholded into bit N-1-k
    function automatic logic [N-1:0] model_frame();
        logic [N-1:0] f;
        f = '0;
        for (int k = 0; k < N; k++) f[N-1-k] = (frame_px[k] >= 128);
        return f;
    endfunction

    task automatic push_pixel(input int v, input logic sof);
        int guard;
        guard = 0;
        bus.pix_in    = 8'(v);
        bus.pix_sof   = sof;
        bus.pix_valid = 1'b1;
        while (bus.pix_ready !== 1'b1 && guard < 50) begin
            @(posedge clk); #1;
            guard++;
        end
        if (guard >= 50) begin
            checks++;
            $display("[TB] FAIL push_timeout pix_ready got %b required 1", bus.pix_ready);
        end
        @(posedge clk); #1;
        bus.pix_valid = 1'b0;
        bus.pix_sof   = 1'b0;
        if (bus.sof_err === 1'b1) sof_err_seen++;
    endtask

    task automatic stream_pixels(input int first, input int last, input int gap_max);
        for (int k = first; k <= last; k++) begin
            push_pixel(frame_px[k], k == 0);
            if (gap_max > 0) begin
                int gaps;
                gaps = $urandom_range(0, gap_max);
                for (int g = 0; g < gaps; g++) begin
                    bus.pix_in = 8'($urandom_range(0, 255));
                    @(posedge clk); #1;
                end
            end
        end
    endtask

    task automatic release_frame();
        bus.img_ack = 1'b1;
        @(posedge clk); #1;
        bus.img_ack = 1'b0;
    endtask

    task automatic randomize_frame();
        for (int k = 0; k < N; k++) frame_px[k] = $urandom_range(0, 255);
    endtask

    task automatic test_reset();
        bus.pix_in = 8'd0; bus.pix_valid = 1'b0; bus.pix_sof = 1'b0; bus.img_ack = 1'b0;
        rst_n = 1'b0;
        #12;
        checks++;
        if (bus.img !== '0 || bus.img_valid !== 1'b0 || bus.sof_err !== 1'b0 || bus.frame_cnt !== 8'd0)
            $display("[TB] FAIL reset_outputs got img_valid=%b sof_err=%b frame_cnt=%0d img=%h required 0/0/0/0",
                     bus.img_valid, bus.sof_err, bus.frame_cnt, bus.img);
        else passed++;
        #11 rst_n = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (bus.pix_ready !== 1'b1) $display("[TB] FAIL reset_ready got %b required 1", bus.pix_ready);
        else passed++;
    endtask

    task automatic test_letter();
        logic [N-1:0] letter;
        letter = 100'b0000000000_0111001110_0111001110_0111001110_0111111110_0111111110_0111001110_0111001110_0111001110_0000000000;
        for (int k = 0; k < N; k++) frame_px[k] = letter[N-1-k] ? 255 : 0;
        stream_pixels(0, N - 2, 0);
        checks++;
        if (bus.img_valid !== 1'b0) $display("[TB] FAIL letter_early_valid got %b required 0", bus.img_valid);
        else passed++;
        stream_pixels(N - 1, N - 1, 0);
        exp_frames++;
        checks++;
        if (bus.img !== letter) $display("[TB] FAIL letter_img got %h required %h", bus.img, letter);
        else passed++;
        checks++;
        if (bus.img_valid !== 1'b1 || bus.frame_cnt !== 8'(exp_frames))
            $display("[TB] FAIL letter_done got valid=%b frame_cnt=%0d required 1/%0d",
                     bus.img_valid, bus.frame_cnt, exp_frames);
        else passed++;
        release_frame();
        checks++;
        if (bus.img_valid !== 1'b0 || bus.pix_ready !== 1'b1 || bus.img !== letter)
            $display("[TB] FAIL letter_release got valid=%b ready=%b img=%h required 0/1/%h",
                     bus.img_valid, bus.pix_ready, bus.img, letter);
        else passed++;
    endtask

    task automatic test_threshold();
        logic [N-1:0] exp_img;
        randomize_frame();
        frame_px[0] = 127;
        frame_px[1] = 128;
        exp_img = model_frame();
        stream_pixels(0, N - 1, 1);
        exp_frames++;
        checks++;
        if (bus.img[99] !== 1'b0 || bus.img[98] !== 1'b1)
            $display("[TB] FAIL thresh_edge got img[99]=%b img[98]=%b required 0/1", bus.img[99], bus.img[98]);
        else passed++;
        checks++;
        if (bus.img !== exp_img) $display("[TB] FAIL thresh_img got %h required %h", bus.img, exp_img);
        else passed++;
        release_frame();
    endtask

    task automatic test_sof_restart();
        logic [N-1:0] exp_img;
        exp_img = {1'b1, 99'b0};
        sof_err_seen = 0;
        for (int k = 0; k < 40; k++) push_pixel($urandom_range(0, 255), k == 0);
        checks++;
        if (sof_err_seen != 0) $display("[TB] FAIL sof_err_spurious got %0d pulses required 0", sof_err_seen);
        else passed++;
        push_pixel(200, 1'b1);
        checks++;
        if (bus.sof_err !== 1'b1) $display("[TB] FAIL sof_err_pulse got %b required 1", bus.sof_err);
        else passed++;
        for (int k = 0; k < 99; k++) push_pixel(0, 1'b0);
        exp_frames++;
        checks++;
        if (bus.img !== exp_img || bus.img_valid !== 1'b1)
            $display("[TB] FAIL sof_restart_img got valid=%b img=%h required 1/%h", bus.img_valid, bus.img, exp_img);
        else passed++;
        checks++;
        if (sof_err_seen != 1 || bus.frame_cnt !== 8'(exp_frames))
            $display("[TB] FAIL sof_restart_count got pulses=%0d frame_cnt=%0d required 1/%0d",
                     sof_err_seen, bus.frame_cnt, exp_frames);
        else passed++;
        release_frame();
    endtask

    task automatic test_hold_backpressure();
        logic [N-1:0] held;
        randomize_frame();
        stream_pixels(0, N - 1, 0);
        exp_frames++;
        held = model_frame();
        checks++;
        if (bus.img !== held || bus.img_valid !== 1'b1)
            $display("[TB] FAIL hold_img got valid=%b img=%h required 1/%h", bus.img_valid, bus.img, held);
        else passed++;
        bus.pix_valid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            bus.pix_sof = c[0];
            bus.pix_in  = 8'($urandom_range(0, 255));
            @(posedge clk); #1;
            checks++;
            if (bus.pix_ready !== 1'b0 || bus.img !== held || bus.img_valid !== 1'b1 || bus.sof_err !== 1'b0)
                $display("[TB] FAIL hold_cycle%0d got ready=%b valid=%b sof_err=%b img=%h required 0/1/0/%h",
                         c, bus.pix_ready, bus.img_valid, bus.sof_err, bus.img, held);
            else passed++;
        end
        bus.pix_sof = 1'b0;
        release_frame();
        bus.pix_valid = 1'b0;
        checks++;
        if (bus.pix_ready !== 1'b1 || bus.img_valid !== 1'b0 || bus.img !== held || bus.frame_cnt !== 8'(exp_frames))
            $display("[TB] FAIL hold_release got ready=%b valid=%b frame_cnt=%0d required 1/0/%0d",
                     bus.pix_ready, bus.img_valid, bus.frame_cnt, exp_frames);
        else passed++;
    endtask

    task automatic test_drop_no_sof();
        logic [N-1:0] prev;
        prev = bus.img;
        for (int k = 0; k < 5; k++) push_pixel($urandom_range(0, 255), 1'b0);
        repeat (3) begin @(posedge clk); #1; end
        checks++;
        if (bus.img_valid !== 1'b0 || bus.frame_cnt !== 8'(exp_frames) || bus.img !== prev)
            $display("[TB] FAIL drop_no_sof got valid=%b frame_cnt=%0d required 0/%0d",
                     bus.img_valid, bus.frame_cnt, exp_frames);
        else passed++;
    endtask

    task automatic test_random_frames();
        logic [N-1:0] exp_img;
        for (int f = 0; f < 3; f++) begin
            randomize_frame();
            exp_img = model_frame();
            bus.img_ack = 1'b1;
            stream_pixels(0, 29, 2);
            bus.img_ack = 1'b0;
            stream_pixels(30, N - 1, 2);
            exp_frames++;
            checks++;
            if (bus.img !== exp_img || bus.img_valid !== 1'b1 || bus.frame_cnt !== 8'(exp_frames))
                $display("[TB] FAIL random_frame%0d got valid=%b frame_cnt=%0d img=%h required 1/%0d/%h",
                         f, bus.img_valid, bus.frame_cnt, bus.img, exp_frames, exp_img);
            else passed++;
            release_frame();
        end
    endtask

    task automatic test_reset_mid_frame();
        logic [N-1:0] exp_img;
        randomize_frame();
        stream_pixels(0, 49, 0);
        rst_n = 1'b0;
        exp_frames = 0;
        #2;
        checks++;
        if (bus.img !== '0 || bus.img_valid !== 1'b0 || bus.sof_err !== 1'b0 ||
            bus.frame_cnt !== 8'd0 || bus.pix_ready !== 1'b1)
            $display("[TB] FAIL midreset_outputs got valid=%b sof_err=%b frame_cnt=%0d ready=%b required 0/0/0/1",
                     bus.img_valid, bus.sof_err, bus.frame_cnt, bus.pix_ready);
        else passed++;
        @(posedge clk); #3;
        rst_n = 1'b1;
        @(posedge clk); #1;
        randomize_frame();
        exp_img = model_frame();
        stream_pixels(0, N - 1, 0);
        exp_frames++;
        checks++;
        if (bus.img !== exp_img || bus.img_valid !== 1'b1 || bus.frame_cnt !== 8'd1)
            $display("[TB] FAIL midreset_frame got valid=%b frame_cnt=%0d img=%h required 1/1/%h",
                     bus.img_valid, bus.frame_cnt, bus.img, exp_img);
        else passed++;
        release_frame();
    endtask

    initial begin
        test_reset();
        test_letter();
        test_threshold();
        test_sof_restart();
        test_hold_backpressure();
        test_drop_no_sof();
        test_random_frames();
        test_reset_mid_frame();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end
endmodule

// File: doc/img_binarize_loader.md
IMG_BINARIZE_LOADER -- requirements
Module: img_binarize_loader

Interface
REQ-001 Parameter W, default 10: image width in pixels.
REQ-002 Parameter H, default 10: image height in pixels; N = W*H, default 100.
REQ-003 Parameter THRESH, default 8'd128: binarization threshold.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous assert, active low.
REQ-006 pix_in  input  8  grayscale pixel, raster order (row 0 first, left to right).
REQ-007 pix_valid  input  1  pix_in valid this cycle.
REQ-008 pix_sof  input  1  start of frame; qualified by pix_valid and marks raster pixel 0.
REQ-009 pix_ready  output  1  block can accept a pixel this cycle.
REQ-010 img  output  N  binarized frame for the contour stage; raster pixel k maps to img[N-1-k].
REQ-011 img_valid  output  1  img holds a complete frame.
REQ-012 img_ack  input  1  consumer has taken img.
REQ-013 sof_err  output  1  one-cycle pulse when a frame restarts before completion.
REQ-014 frame_cnt  output  8  count of completed frames, modulo 256.

Function
REQ-015 A pixel is accepted on a rising edge with pix_valid=1 and pix_ready=1; otherwise there is no transfer.
REQ-016 Binarization: bit = 1 iff pix_in >= THRESH, unsigned compare.
REQ-017 FSM states: IDLE, FILL, HOLD.
REQ-018 IDLE: pix_ready=1; an accepted pixel with pix_sof=1 writes bit 0, sets pixel count to 1, and moves to FILL.
REQ-019 IDLE: an accepted pixel with pix_sof=0 is consumed and discarded; the state stays IDLE.
REQ-020 FILL: pix_ready=1; an accepted pixel with pix_sof=0 is written at the current count and the count increments.
REQ-021 FILL: an accepted pixel with pix_sof=1 discards the partial frame, writes that pixel as pixel 0, sets count to 1, and pulses sof_err on the next cycle.
REQ-022 Pixels are assembled in an internal N-bit shift/fill register; img changes only at frame completion.
REQ-023 Frame completion: the cycle after pixel N-1 is accepted, img is loaded with all N bits, img_valid=1, frame_cnt increments (255 wraps to 0), and the FSM enters HOLD.
REQ-024 Latency: 1 cycle from acceptance of pixel N-1 to img_valid high.
REQ-025 Completion with W=H=1: a single accepted pixel with pix_sof=1 completes the frame directly from IDLE.
REQ-026 HOLD: pix_ready=0; img and img_valid are stable until img_ack=1.
REQ-027 HOLD with img_ack=1: img_valid=0 next cycle and FSM returns to IDLE; img keeps its last value.
REQ-028 img_ack outside HOLD is ignored.
REQ-029 pix_sof asserted while pix_ready=0 is not a transfer and has no effect.
REQ-030 pix_ready is a registered function of state only, with no combinational path from pix_valid or img_ack.
REQ-031 The pixel counter width is ceil(log2(N+1)); the counter never exceeds N-1 while in FILL.

Reset
REQ-032 rst_n=0 asynchronously forces: state IDLE, count 0, img all zeros, img_valid 0, sof_err 0, frame_cnt 0.
REQ-033 Reset mid-FILL or during HOLD discards the partial or held frame and does not increment frame_cnt.
REQ-034 pix_ready=1 from the first rising edge after rst_n deasserts.

Verification
REQ-035 Stream the 100 pixels of the test letter pattern (255 for 1, 0 for 0) with sof on pixel 0 -> img = 100'b0000000000011100111001110011100111001110011111111001111111100111001110011100111001110011100000000000, img_valid=1 one cycle after the last pixel, and frame_cnt=1.
REQ-036 Pixel values 127 and 128 at THRESH=128 -> bits 0 and 1 respectively.
REQ-037 40 pixels, then sof with pixel value 200, then 99 pixels of 0 -> sof_err pulses once, img[99]=1, img[98:0]=0.
REQ-038 Frame held with pix_valid=1 continuously, img_ack asserted 5 cycles late -> pix_ready=0 and img stable for those cycles; pix_ready=1 the cycle after ack.
REQ-039 5 pixels without sof from IDLE -> all dropped, img_valid stays 0, frame_cnt unchanged.
REQ-040 rst_n pulsed low after pixel 50 -> all outputs at reset values immediately; a subsequent full frame completes correctly with frame_cnt=1.
